clk_div_multi: RTL
==================

Name: clk_div_multi

Overview:
- Parametrised multi-channel successor to the single terminal-count clock divider.
- Each channel runs its own counter with its own terminal value. Each channel has one of four modes: periodic pulse, toggle (square wave), retriggerable one-shot, or off.
- Provides the CPU clock-phase ticks, display/scan strobes and debounce timers from one shared system clock. Common enable and synchronous clear.

Parameters:
- WIDTH, 24, counter and terminal-value width per channel.
- CHANNELS, 2, number of independent channels (>=1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (low = reset).
- en  input  1  global count enable; counters advance only when high.
- clr  input  1  synchronous clear of all channels; highest priority after rst.
- max_count  input  CHANNELS*WIDTH  terminal value per channel; channel i uses bits [i*WIDTH +: WIDTH].
- mode  input  2*CHANNELS  per channel: 00 periodic, 01 toggle, 10 one-shot, 11 off.
- start  input  CHANNELS  per-channel one-shot trigger; ignored in other modes.
- tc  output  CHANNELS  registered one-cycle terminal-count pulse.
- sq  output  CHANNELS  registered square-wave output (toggle mode only).
- busy  output  CHANNELS  registered; high while a one-shot is running.

Behaviour:
- Reset (rst low, asynchronous):
  - count, tc, sq, busy and the stored mode_q all go to 0 immediately.
  - Outputs stay 0 until the first rising edge after rst returns high.
- Priority per edge: rst > clr > mode change > start > en/count.
- clr high: every count, tc, sq and busy is 0 on the next edge. start and en are ignored that cycle.
- Mode change: if mode[i] differs from mode_q[i], channel i loads count=0, tc=0, sq=0, busy=0 and mode_q[i]<=mode[i]. The new mode takes effect the following cycle.
- Wrap condition per channel: en && (count >= max_count[i]). This uses an unsigned >= compare.
- Periodic (00):
  - On wrap: count<=0, tc<=1.
  - Otherwise, if en: count<=count+1, tc<=0.
  - tc is high 1 cycle in every max+1 enabled cycles.
- Toggle (01): same count and tc behaviour as periodic; sq inverts on every wrap. The sq period is 2*(max+1) enabled cycles, 50% duty.
- One-shot (10):
  - Idle: busy=0, count held 0, tc=0.
  - start while idle or busy: count<=0, busy<=1. A start while busy retriggers and restarts the count.
  - While busy and en: count increments.
  - On wrap while busy: tc<=1, busy<=0, count<=0.
  - tc fires exactly once per trigger, max+1 enabled cycles after the start edge.
- Off (11): count, tc, sq and busy are held at 0.
- en low: counts freeze, tc<=0, sq and busy hold.
- max=0: wrap on every enabled cycle. In periodic mode tc stays high continuously; in toggle mode sq toggles every cycle.
- max_count lowered below the current count: the channel wraps on the next enabled cycle (>= compare). No overflow past max is possible.
- Counter arithmetic is WIDTH-bit unsigned. count never exceeds max_count except transiently after max_count is lowered.
- Channels are fully independent except for the shared en and clr.
- No combinational paths from inputs to outputs.

Test Plan:
- Reset and periodic count:
  - Stimulus: rst low mid-count, en=1; then release rst with ch0 mode=00, max=3.
  - Response: all outputs 0 while rst is low. After release, tc[0] is high 1 cycle every 4 cycles; first pulse on the 4th edge after release.
- Toggle mode:
  - Stimulus: ch1 mode=01, max=4, en=1 for 40 cycles.
  - Response: sq[1] period 10 cycles, high 5 and low 5. tc[1] pulses every 5 cycles.
- One-shot:
  - Stimulus: ch0 mode=10, max=5, start pulse at cycle 10; second start at cycle 13.
  - Response: busy high from cycle 11. The cycle-13 start retriggers, so tc fires once at 6 cycles after cycle 13. No tc at cycle 16.
- Enable gating and max=0:
  - Stimulus: ch0 periodic, max=0, en toggled 1/0 every 2 cycles.
  - Response: tc follows en delayed 1 cycle; no tc on disabled cycles.
- Live change:
  - Stimulus: periodic, max=10, count at 7; drop max to 3, then switch mode to 11.
  - Response: wrap and tc on the next enabled cycle. On the mode switch, count, tc and sq are 0 and held.
- clr priority:
  - Stimulus: clr asserted the same cycle as start and a wrap.
  - Response: no tc pulse, busy=0, count=0 on the next edge.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel terminal-count divider: each channel runs a counter against its own
// terminal value in periodic, toggle, retriggerable one-shot or off mode.
module clk_div_multi #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic [CHANNELS*WIDTH-1:0] max_count,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       start,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       sq,
    output logic [CHANNELS-1:0]       busy
);

    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'b00,
        MODE_TOGGLE   = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_OFF      = 2'b11
    } mode_t;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] count_reg, count_next;
            logic [WIDTH-1:0] max_val;
            mode_t            mode_reg, mode_next, mode_in;
            logic             tc_reg, tc_next;
            logic             sq_reg, sq_next;
            logic             busy_reg, busy_next;
            logic             wrap;

            assign max_val = max_count[gi*WIDTH +: WIDTH];
            assign mode_in = mode_t'(mode[2*gi +: 2]);
            // >= so a terminal value lowered below the count still wraps immediately
            assign wrap    = en && (count_reg >= max_val);

            always_comb begin
                count_next = count_reg;
                mode_next  = mode_reg;
                tc_next    = 1'b0;
                sq_next    = sq_reg;
                busy_next  = busy_reg;
                if (clr) begin
                    count_next = '0;
                    sq_next    = 1'b0;
                    busy_next  = 1'b0;
                end else if (mode_in != mode_reg) begin
                    count_next = '0;
                    sq_next    = 1'b0;
                    busy_next  = 1'b0;
                    mode_next  = mode_in;
                end else begin
                    case (mode_reg)
                        MODE_PERIODIC, MODE_TOGGLE: begin
                            if (wrap) begin
                                count_next = '0;
                                tc_next    = 1'b1;
                                if (mode_reg == MODE_TOGGLE) begin
                                    sq_next = ~sq_reg;
                                end
                            end else if (en) begin
                                count_next = count_reg + 1'b1;
                            end
                        end
                        MODE_ONESHOT: begin
                            // a start while running restarts the interval
                            if (start[gi]) begin
                                count_next = '0;
                                busy_next  = 1'b1;
                            end else if (busy_reg) begin
                                if (wrap) begin
                                    count_next = '0;
                                    tc_next    = 1'b1;
                                    busy_next  = 1'b0;
                                end else if (en) begin
                                    count_next = count_reg + 1'b1;
                                end
                            end
                        end
                        default: begin
                            count_next = '0;
                            sq_next    = 1'b0;
                            busy_next  = 1'b0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    count_reg <= '0;
                    mode_reg  <= MODE_PERIODIC;
                    tc_reg    <= 1'b0;
                    sq_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                end else begin
                    count_reg <= count_next;
                    mode_reg  <= mode_next;
                    tc_reg    <= tc_next;
                    sq_reg    <= sq_next;
                    busy_reg  <= busy_next;
                end
            end

            assign tc[gi]   = tc_reg;
            assign sq[gi]   = sq_reg;
            assign busy[gi] = busy_reg;
        end
    endgenerate

endmodule
